// File: rtl/dcache_refill_fsm.sv
// D-cache miss sequencer: requests the aligned line, writes beats into the arrays, then releases MEM.
// Optional DCACHE_REFILL_STATS_EN adds miss/stall counters and a busy flag.
module dcache_refill_fsm #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 5,
  localparam int WORD_BITS = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  tag_hit,
  output logic                  mem_done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  refill_we,
  output logic [INDEX_BITS-1:0] refill_index,
  output logic [WORD_BITS-1:0]  refill_word,
  output logic [DATA_WIDTH-1:0] refill_data,
  output logic                  tag_we
`ifdef DCACHE_REFILL_STATS_EN
  ,
  output logic [31:0]           miss_count,
  output logic [31:0]           stall_cycles,
  output logic [0:0]            fill_busy
`endif
);

  localparam int OFF_BITS = WORD_BITS + 2;
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2, COMMIT = 2'd3} state_t;

  state_t                state;
  logic [WORD_BITS-1:0]  beat;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  miss;

  assign miss = req_valid & ~tag_hit;

  // State, beat counter and latched miss address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            addr  <= req_addr;
            state <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) state <= FILL;
        end
        FILL: begin
          if (mem_rsp_valid) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= COMMIT;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Beat writes and tag commit follow the memory response in the same cycle
  always_comb begin
    mem_done      = 1'b1;
    mem_req_valid = 1'b0;
    refill_we     = 1'b0;
    tag_we        = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: mem_done = ~miss;
        REQ: begin
          mem_done      = 1'b0;
          mem_req_valid = 1'b1;
        end
        FILL: begin
          mem_done  = 1'b0;
          refill_we = mem_rsp_valid;
          tag_we    = mem_rsp_valid & (beat == LAST_BEAT);
        end
        COMMIT:  mem_done = 1'b1;
        default: mem_done = 1'b1;
      endcase
    end else begin
      mem_done = 1'b1;
    end
  end

  assign mem_req_addr = {addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign refill_index = addr[OFF_BITS+INDEX_BITS-1:OFF_BITS];
  assign refill_word  = beat;
  assign refill_data  = mem_rsp_data;

`ifdef DCACHE_REFILL_STATS_EN
`ifdef SIMULATION
  function automatic void stats_event(input string name);
  endfunction
`endif

  // Saturating miss and stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count   <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      if (state == IDLE && miss && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
      if (!mem_done && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
`ifdef SIMULATION
      if (state == COMMIT) stats_event("dc_refill");
`endif
    end
  end

  assign fill_busy = 1'(state != IDLE);
`endif

endmodule

// File: tb/tb_dcache_refill_fsm.sv
// Self-checking bench for dcache_refill_fsm: directed miss scenarios plus randomized traffic
// against a transaction-level model of the refill sequence.
module tb_dcache_refill_fsm;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int IB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          tag_hit = 1'b0;
  logic          mem_done;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          refill_we;
  logic [IB-1:0] refill_index;
  logic [1:0]    refill_word;
  logic [DW-1:0] refill_data;
  logic          tag_we;
`ifdef DCACHE_REFILL_STATS_EN
  logic [31:0]   miss_count;
  logic [31:0]   stall_cycles;
  logic [0:0]    fill_busy;
`endif

  int checks = 0;
  int passes = 0;

  dcache_refill_fsm dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .tag_hit(tag_hit),
    .mem_done(mem_done), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .refill_we(refill_we), .refill_index(refill_index), .refill_word(refill_word),
    .refill_data(refill_data), .tag_we(tag_we)
`ifdef DCACHE_REFILL_STATS_EN
    , .miss_count(miss_count), .stall_cycles(stall_cycles), .fill_busy(fill_busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
  endtask

  // Transaction model: an outstanding miss, whether its request is still pending,
  // beats received so far, and the one-cycle release after the last beat.
  logic          m_busy = 1'b0;
  logic          m_req = 1'b0;
  logic          m_commit = 1'b0;
  int            m_beats = 0;
  logic [AW-1:0] m_addr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_req <= 1'b0; m_commit <= 1'b0; m_beats <= 0; m_addr <= '0;
    end else if (m_commit) begin
      m_commit <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid && !tag_hit) begin
        m_busy <= 1'b1; m_req <= 1'b1; m_addr <= req_addr;
      end
    end else if (m_req) begin
      if (mem_req_ready) m_req <= 1'b0;
    end else if (mem_rsp_valid) begin
      if (m_beats == LW - 1) begin
        m_busy <= 1'b0; m_commit <= 1'b1; m_beats <= 0;
      end else begin
        m_beats <= m_beats + 1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    logic e_done, e_rv, e_we, e_tw;
    logic [AW-1:0] line_addr;
    e_done = 1'b1; e_rv = 1'b0; e_we = 1'b0; e_tw = 1'b0;
    line_addr = (m_addr / (LW * 4)) * (LW * 4);
    if (rst) begin
      e_done = 1'b1;
    end else if (m_commit) begin
      e_done = 1'b1;
    end else if (!m_busy) begin
      e_done = !(req_valid && !tag_hit);
    end else if (m_req) begin
      e_done = 1'b0; e_rv = 1'b1;
    end else begin
      e_done = 1'b0; e_we = mem_rsp_valid; e_tw = mem_rsp_valid && (m_beats == LW - 1);
    end
    chk("mem_done", 64'(mem_done), 64'(e_done));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(e_rv));
    chk("refill_we", 64'(refill_we), 64'(e_we));
    chk("tag_we", 64'(tag_we), 64'(e_tw));
    if (e_rv) chk("mem_req_addr", 64'(mem_req_addr), 64'(line_addr));
    if (e_we) begin
      chk("refill_word", 64'(refill_word), 64'(m_beats));
      chk("refill_data", 64'(refill_data), 64'(mem_rsp_data));
      chk("refill_index", 64'(refill_index), 64'((m_addr / (LW * 4)) % (1 << IB)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One miss with the given request backpressure and inter-beat gap; literal expectations
  task automatic do_miss(input logic [AW-1:0] a, input logic [AW-1:0] exp_line,
                         input logic [IB-1:0] exp_idx, input int delay, input int gap);
    int low = 0;
    int wes = 0;
    int tws = 0;
    req_valid = 1'b1; tag_hit = 1'b0; req_addr = a; mem_req_ready = 1'b0;
    @(negedge clk); if (!mem_done) low++;
    step();
    for (int d = 0; d < delay; d++) begin
      @(negedge clk); if (!mem_done) low++;
      chk("req_held_valid", 64'(mem_req_valid), 64'd1);
      chk("req_held_addr", 64'(mem_req_addr), 64'(exp_line));
      step();
    end
    mem_req_ready = 1'b1;
    @(negedge clk); if (!mem_done) low++;
    chk("req_addr_line", 64'(mem_req_addr), 64'(exp_line));
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < LW; i++) begin
      for (int g = 0; g < (i == 0 ? 0 : gap); g++) begin
        mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        @(negedge clk); if (!mem_done) low++;
        if (refill_we) wes++;
        if (tag_we) tws++;
        step();
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hD000_0000 + 32'(i);
      @(negedge clk); if (!mem_done) low++;
      if (refill_we) wes++;
      if (tag_we) tws++;
      chk("beat_word", 64'(refill_word), 64'(i));
      chk("beat_index", 64'(refill_index), 64'(exp_idx));
      step();
    end
    mem_rsp_valid = 1'b0; tag_hit = 1'b1;
    @(negedge clk);
    chk("commit_done", 64'(mem_done), 64'd1);
    chk("low_cycles", 64'(low), 64'(LW + 2 + delay + 3 * gap));
    chk("we_count", 64'(wes), 64'(LW));
    chk("tag_we_count", 64'(tws), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; tag_hit = 1'b0;
    step(); step();
    @(negedge clk);
    chk("reset_done", 64'(mem_done), 64'd1);
    chk("reset_req_valid", 64'(mem_req_valid), 64'd0);
    rst = 1'b0; req_valid = 1'b0;
    step();

    // Hit in IDLE
    req_valid = 1'b1; tag_hit = 1'b1; req_addr = 32'h0000_0040;
    @(negedge clk);
    chk("hit_done", 64'(mem_done), 64'd1);
    chk("hit_no_req", 64'(mem_req_valid), 64'd0);
    chk("hit_no_we", 64'(refill_we), 64'd0);
    step();

    do_miss(32'h0000_1234, 32'h0000_1230, 5'h03, 0, 0);
    do_miss(32'h0000_2F08, 32'h0000_2F00, 5'h10, 0, 0);
`ifdef DCACHE_REFILL_STATS_EN
    chk("stat_miss_count", 64'(miss_count), 64'd2);
    chk("stat_stall_cycles", 64'(stall_cycles), 64'd12);
`endif
    do_miss(32'hABCD_007C, 32'hABCD_0070, 5'h07, 3, 0);
    do_miss(32'h0000_01F4, 32'h0000_01F0, 5'h1F, 1, 2);

    // Reset at beat 2 aborts the fill
    req_valid = 1'b1; tag_hit = 1'b0; req_addr = 32'h0000_5550; mem_req_ready = 1'b1;
    step(); step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
    step(); step();
    rst = 1'b1;
    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_we", 64'(refill_we), 64'd0);
    chk("rst_tag_we", 64'(tag_we), 64'd0);
    chk("rst_done", 64'(mem_done), 64'd1);
    step();
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("stray_beat_we", 64'(refill_we), 64'd0);
    chk("stray_beat_tag", 64'(tag_we), 64'd0);
    step();
    mem_rsp_valid = 1'b0;

    // Randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      req_valid = $urandom_range(0, 1);
      tag_hit = ($urandom_range(0, 3) != 0);
      req_addr = $urandom;
      mem_req_ready = $urandom_range(0, 1);
      mem_rsp_valid = $urandom_range(0, 1);
      mem_rsp_data = $urandom;
      step();
    end
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
